// File: rtl/fpu_op_sequencer.sv
// Single-issue FPU op sequencer: accepts one-hot decoded ops, dispatches fdiv/fsqrt
// to the shared iterative unit with a bounded wait, and emits one writeback per legal op.
module fpu_op_sequencer #(
  parameter int OP_W    = 24,
  parameter int TIMEOUT = 63,
  parameter int CNT_W   = 6
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [OP_W-1:0] sfpu,
  input  logic [4:0]      rd_addr,
  output logic            div_start,
  output logic            sqrt_start,
  input  logic            unit_done,
  output logic            multi_cycle,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic            timeout_err,
  output logic            illegal_op,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [4:0]       rd_q, rd_d;
  logic             div_d, sqrt_d, wb_d, tmo_d, ill_d;
  logic             accept, legal, iterative;

  // Bits 23:22 are signed/unsigned modifiers and play no part in sequencing.
  logic unused_mod;
  assign unused_mod = ^sfpu[23:22];

  assign op_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign multi_cycle = (state == ISSUE) || (state == WAIT);
  assign wb_rd       = rd_q;

  assign accept    = op_valid && op_ready;
  assign legal     = $onehot(sfpu[21:0]);
  assign iterative = sfpu[3] || sfpu[4];

  // Pulses are computed alongside the transition and registered, so each one
  // appears in the cycle of the state it belongs to.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rd_d    = rd_q;
    div_d   = 1'b0;
    sqrt_d  = 1'b0;
    wb_d    = 1'b0;
    tmo_d   = 1'b0;
    ill_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (!legal) begin
            ill_d = 1'b1;
          end else begin
            rd_d = rd_addr;
            if (iterative) begin
              state_d = ISSUE;
              div_d   = sfpu[3];
              sqrt_d  = sfpu[4];
            end else begin
              state_d = WB;
              wb_d    = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (unit_done) begin
          state_d = WB;
          wb_d    = 1'b1;
        end else if (cnt == CNT_LIMIT) begin
          state_d = WB;
          wb_d    = 1'b1;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state       <= IDLE;
      cnt         <= '0;
      rd_q        <= '0;
      div_start   <= 1'b0;
      sqrt_start  <= 1'b0;
      wb_valid    <= 1'b0;
      timeout_err <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      rd_q        <= rd_d;
      div_start   <= div_d;
      sqrt_start  <= sqrt_d;
      wb_valid    <= wb_d;
      timeout_err <= tmo_d;
      illegal_op  <= ill_d;
    end
  end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed self-checking bench for fpu_op_sequencer.
module tb_fpu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        op_valid;
  logic        op_ready;
  logic [23:0] sfpu;
  logic [4:0]  rd_addr;
  logic        div_start, sqrt_start;
  logic        unit_done;
  logic        multi_cycle;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        timeout_err, illegal_op, busy;

  int errors = 0;
  int checks = 0;

  fpu_op_sequencer #(.OP_W(24), .TIMEOUT(63), .CNT_W(6)) dut (
    .clk(clk), .rst_l(rst_l), .op_valid(op_valid), .op_ready(op_ready),
    .sfpu(sfpu), .rd_addr(rd_addr), .div_start(div_start), .sqrt_start(sqrt_start),
    .unit_done(unit_done), .multi_cycle(multi_cycle), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .timeout_err(timeout_err), .illegal_op(illegal_op), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [23:0] op, input logic [4:0] rd);
    op_valid = 1'b1;
    sfpu     = op;
    rd_addr  = rd;
  endtask

  int n;

  initial begin
    rst_l = 1'b0; op_valid = 1'b0; sfpu = '0; rd_addr = '0; unit_done = 1'b0;
    #12;
    check("rst_op_ready", op_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_wb", {wb_valid, timeout_err, illegal_op, div_start, sqrt_start, multi_cycle}, 0);
    check("rst_wb_rd", wb_rd, 0);
    @(negedge clk); rst_l = 1'b1;
    tick();

    // fadd, rd=7
    issue(24'h000001, 5'd7);
    check("fadd_ready", op_ready, 1);
    tick();
    op_valid = 1'b0;
    check("fadd_wb", wb_valid, 1);
    check("fadd_rd", wb_rd, 7);
    check("fadd_mc", multi_cycle, 0);
    tick();
    check("fadd_wb_off", wb_valid, 0);
    check("fadd_idle", op_ready, 1);

    // back-to-back fadd with op_valid held: one op per 2 cycles
    issue(24'h000001, 5'd5);
    tick();
    check("b2b_wb1", wb_valid, 1);
    check("b2b_ready0", op_ready, 0);
    tick();
    check("b2b_gap", wb_valid, 0);
    tick();
    op_valid = 1'b0;
    check("b2b_wb2", wb_valid, 1);
    check("b2b_rd2", wb_rd, 5);
    tick();

    // fdiv, rd=3, unit_done 10 cycles after div_start
    issue(24'h000008, 5'd3);
    tick();
    op_valid = 1'b0;
    check("div_start", div_start, 1);
    check("div_sqrt0", sqrt_start, 0);
    check("div_mc_issue", multi_cycle, 1);
    check("div_ready0", op_ready, 0);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("div_mc_wait", multi_cycle, 1);
      check("div_start_off", div_start, 0);
    end
    unit_done = 1'b1;
    tick();
    unit_done = 1'b0;
    check("div_wb", wb_valid, 1);
    check("div_rd", wb_rd, 3);
    check("div_tmo", timeout_err, 0);
    check("div_mc_wb", multi_cycle, 0);
    tick();

    // fsqrt with no unit_done: timeout after exactly 63 WAIT cycles
    issue(24'h000010, 5'd12);
    tick();
    op_valid = 1'b0;
    check("sqrt_start", sqrt_start, 1);
    check("sqrt_div0", div_start, 0);
    tick();
    n = 0;
    while (multi_cycle && n < 200) begin
      n++;
      tick();
    end
    check("tmo_wait_cycles", n, 63);
    check("tmo_err", timeout_err, 1);
    check("tmo_wb", wb_valid, 1);
    check("tmo_rd", wb_rd, 12);
    tick();
    check("tmo_ready", op_ready, 1);
    check("tmo_err_off", timeout_err, 0);

    // unit_done exactly at counter == TIMEOUT-1: done wins
    issue(24'h000008, 5'd20);
    tick();
    op_valid = 1'b0;
    tick();
    for (int i = 0; i < 62; i++) tick();
    check("edge_still_wait", multi_cycle, 1);
    unit_done = 1'b1;
    tick();
    unit_done = 1'b0;
    check("edge_wb", wb_valid, 1);
    check("edge_tmo", timeout_err, 0);
    check("edge_rd", wb_rd, 20);
    tick();

    // illegal ops: two bits set, modifier only
    issue(24'h000006, 5'd1);
    tick();
    check("ill2_pulse", illegal_op, 1);
    check("ill2_wb", wb_valid, 0);
    check("ill2_ready", op_ready, 1);
    issue(24'h800000, 5'd2);
    tick();
    op_valid = 1'b0;
    check("illmod_pulse", illegal_op, 1);
    check("illmod_wb", wb_valid, 0);
    check("illmod_ready", op_ready, 1);
    tick();
    check("ill_off", illegal_op, 0);
    check("ill_wb_off", wb_valid, 0);

    // async reset mid-WAIT, then a late unit_done
    issue(24'h000008, 5'd4);
    tick();
    op_valid = 1'b0;
    tick(); tick(); tick();
    check("ar_in_wait", multi_cycle, 1);
    #2 rst_l = 1'b0;
    #1;
    check("ar_mc", multi_cycle, 0);
    check("ar_busy", busy, 0);
    check("ar_ready", op_ready, 1);
    @(negedge clk); rst_l = 1'b1;
    unit_done = 1'b1;
    tick();
    unit_done = 1'b0;
    check("ar_late_wb", wb_valid, 0);
    check("ar_late_pulses", {timeout_err, div_start, sqrt_start, illegal_op}, 0);
    check("ar_late_busy", busy, 0);
    issue(24'h000001, 5'd9);
    tick();
    op_valid = 1'b0;
    check("ar_fadd_wb", wb_valid, 1);
    check("ar_fadd_rd", wb_rd, 9);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/fpu_op_sequencer.md
Name: fpu_op_sequencer

Overview:
- Single-issue sequencer between the FPU fetch/decode FSM and the FPU execution units.
- Accepts one decoded operation at a time as a 24-bit one-hot opcode plus destination register.
- Dispatches iterative ops (fdiv, fsqrt) to the shared iterative unit and holds the fetch FSM stalled via multi_cycle until that unit finishes or times out.
- Produces exactly one writeback strobe per accepted legal op.

Parameters:
OP_W, 24, one-hot opcode width; bit map: 0 fadd, 1 fsub, 2 fmul, 3 fdiv, 4 fsqrt, 5 fmin, 6 fmax, 7 fmvx, 8 fmvf, 9 feq, 10 flt, 11 fle, 12 fmadd, 13 fmsub, 14 fcvt.w.s, 15 fcvt.s.w, 16 fnmsub, 17 fnmadd, 18 fsgnj, 19 fsgnjn, 20 fsgnjx, 21 fclass, 22 unsigned, 23 signed
TIMEOUT, 63, maximum WAIT cycles before forced abort (1..2^CNT_W-1)
CNT_W, 6, wait counter width

Ports:
clk  in  1  clock, all state on rising edge
rst_l  in  1  asynchronous active-low reset
op_valid  in  1  decoded op present
op_ready  out  1  sequencer can accept an op this cycle
sfpu  in  OP_W  one-hot opcode; bits 22/23 are modifiers and are excluded from the one-hot check
rd_addr  in  5  destination register
div_start  out  1  one-cycle start pulse to iterative unit, divide
sqrt_start  out  1  one-cycle start pulse to iterative unit, sqrt
unit_done  in  1  iterative unit result valid (single-cycle pulse)
multi_cycle  out  1  stall to fetch FSM
wb_valid  out  1  one-cycle writeback strobe
wb_rd  out  5  destination for wb_valid
timeout_err  out  1  one-cycle pulse, iterative op aborted
illegal_op  out  1  one-cycle pulse, accepted op not one-hot in bits 21:0
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_l=0, asynchronous): state=IDLE, counter=0, latched rd=0; all outputs 0 except op_ready=1.
- States: IDLE, ISSUE, WAIT, WB (2-bit encoded).
- op_ready = (state==IDLE). Accept = op_valid & op_ready.
- Legality: sfpu[21:0] has exactly one bit set.

IDLE:
- On accept with an illegal op: illegal_op=1 next cycle. The op is consumed; no wb_valid; state stays IDLE.
- On accept with a legal op and sfpu[3]|sfpu[4]=0: latch rd, go WB. wb_valid is asserted the cycle after accept (latency 1).
- On accept with a legal op and sfpu[3] or sfpu[4]: latch rd and op kind, go ISSUE.

ISSUE (1 cycle):
- div_start or sqrt_start=1 according to the latched kind.
- counter cleared; go WAIT.

WAIT:
- Each cycle: if unit_done, go WB; else if counter==TIMEOUT-1, go WB and pulse timeout_err on entry to WB; else counter+1.
- unit_done and the timeout limit in the same cycle: done wins, no timeout_err.

WB (1 cycle):
- wb_valid=1, wb_rd=latched rd; go IDLE.
- wb_valid is also asserted on timeout; the consumer uses timeout_err to discard the result.

Other rules:
- multi_cycle = (state==ISSUE)|(state==WAIT), combinational from state.
- unit_done outside WAIT is ignored.
- op_valid while not ready is held by the source; the sequencer does not sample it.
- Back-to-back single-cycle ops: accept, WB, accept, ... gives one op per 2 cycles.
- Reset asserted in ISSUE or WAIT: immediate return to IDLE, no start, wb or err pulse. A late unit_done after reset is ignored.
- All pulses are registered outputs, except op_ready, multi_cycle and busy, which are decoded from state.

Test Plan:
- Reset, then op_valid=1, sfpu=24'h000001 (fadd), rd=5'd7 -> op_ready=1 at accept; next cycle wb_valid=1, wb_rd=7, multi_cycle=0 throughout.
- sfpu=24'h000008 (fdiv), rd=3; unit_done 10 cycles after div_start -> div_start 1 cycle after accept; multi_cycle=1 from ISSUE through WAIT; wb_valid with wb_rd=3 one cycle after unit_done; no timeout_err.
- sfpu=24'h000010 (fsqrt), unit_done never asserted, TIMEOUT=63 -> sqrt_start pulse; exactly 63 WAIT cycles; timeout_err=1 and wb_valid=1 in the same cycle; op_ready=1 the following cycle.
- unit_done asserted on the same cycle the counter hits TIMEOUT-1 -> wb_valid=1, timeout_err=0.
- sfpu=24'h000006 (two bits) and sfpu=24'h800000 (modifier only) -> illegal_op pulse each; no wb_valid; op_ready stays 1.
- rst_l pulsed low asynchronously mid-WAIT, then unit_done=1 after release -> multi_cycle, busy and all pulses drop immediately; no wb_valid; next fadd completes normally with 1-cycle latency.
